muldiv_ctrl: RTL and testbench

Iterative RV32M multiply/divide sequencer in the EX stage of the 5-stage pipeline. It accepts an M-extension operation while the instruction sits in EX and raises a stall request so the hazard logic freezes IF/ID/EX. It runs a shift-add multiply or a restoring divide over 32 cycles, then pulses the result for one cycle so EX can advance. A flush aborts the operation cleanly.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_datapath.sv | 141 ++++++++++++++
 rtl/muldiv_ctrl.sv | 83 ++++++++
 tb/tb_muldiv_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M iterative multiply/divide sequencer.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply).
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline <-> multiply/divide sequencer handshake bundle.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            req_valid;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            stall_req;
  logic            res_valid;
  logic [XLEN-1:0] res_data;

  // EX-stage / hazard side
  modport master (
    output req_valid, req_op, req_a, req_b, flush,
    input  stall_req, res_valid, res_data
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, flush,
    output stall_req, res_valid, res_data
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand magnitude conversion, shift-add / restoring-divide step and sign fixup.
// Optional feature macro: MULDIV_FAST_MUL_EN (full product in one step).
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            single_step_o,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]        op_q, op_d;
  logic              a_neg_q, a_neg_d;
  logic              res_neg_q, res_neg_d;
  logic              b_zero_q, b_zero_d;
  logic [XLEN-1:0]   a_orig_q, a_orig_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0]   b_orig_q, b_orig_d;
  logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
`endif

  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_neg_q   <= 1'b0;
      res_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_orig_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
`ifdef MULDIV_FAST_MUL_EN
      b_orig_q  <= '0;
`endif
    end else begin
      op_q      <= op_d;
      a_neg_q   <= a_neg_d;
      res_neg_q <= res_neg_d;
      b_zero_q  <= b_zero_d;
      a_orig_q  <= a_orig_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
`ifdef MULDIV_FAST_MUL_EN
      b_orig_q  <= b_orig_d;
`endif
    end
  end

  // Operand capture on accept, one iteration step per CALC cycle
  always_comb begin
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    res_neg_d = res_neg_q;
    b_zero_d  = b_zero_q;
    a_orig_d  = a_orig_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
`ifdef MULDIV_FAST_MUL_EN
    b_orig_d  = b_orig_q;
    ext_a     = {{XLEN{op_a_signed(op_q) & a_orig_q[XLEN-1]}}, a_orig_q};
    ext_b     = {{XLEN{op_b_signed(op_q) & b_orig_q[XLEN-1]}}, b_orig_q};
    fast_prod = ext_a * ext_b;
`endif

    a_neg_in = op_a_signed(op_i) & a_i[XLEN-1];
    b_neg_in = op_b_signed(op_i) & b_i[XLEN-1];
    a_mag    = a_neg_in ? -a_i : a_i;
    b_mag    = b_neg_in ? -b_i : b_i;

    // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}, shifted left
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};

    if (load_i) begin
      op_d      = op_i;
      a_neg_d   = a_neg_in;
      res_neg_d = a_neg_in ^ b_neg_in;
      b_zero_d  = (b_i == '0);
      a_orig_d  = a_i;
`ifdef MULDIV_FAST_MUL_EN
      b_orig_d  = b_i;
`endif
      if (op_is_div(op_i)) begin
        opnd_d = b_mag;
        acc_d  = {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd_d = a_mag;
        acc_d  = {{XLEN{1'b0}}, b_mag};
      end
    end else if (step_i) begin
      if (op_is_div(op_q)) begin
        if (!div_diff[XLEN])
          acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        acc_d = fast_prod;
`else
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
`endif
      end
    end
  end

  // Sign and special-case fixup of the finished iteration
  always_comb begin
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
`ifdef MULDIV_FAST_MUL_EN
    prod          = acc_q;
    single_step_o = !op_is_div(op_q);
`else
    prod          = res_neg_q ? -acc_q : acc_q;
    single_step_o = 1'b0;
`endif
    quo = res_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                      result_o = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result_o = b_zero_q ? '1 : quo;
      default:                     result_o = b_zero_q ? a_orig_q : rem;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer for the EX stage: FSM, iteration counter,
// stall/flush handling and registered result.
// Optional feature macro: MULDIV_FAST_MUL_EN (multiply completes in one CALC cycle).
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] res_data_q, res_data_d;

  logic            load, step, stall, single_step;
  logic [XLEN-1:0] dp_result;

  muldiv_datapath u_datapath (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load),
    .step_i        (step),
    .op_i          (bus.req_op),
    .a_i           (bus.req_a),
    .b_i           (bus.req_b),
    .single_step_o (single_step),
    .result_o      (dp_result)
  );

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Next-state and counter; flush returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          state_d = CALC;
          cnt_d   = CNT_W'(ITERS - 1);
        end
        CALC: if (cnt_q == '0 || single_step) state_d = FIX;
              else cnt_d = cnt_q - 1'b1;
        FIX:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath controls, stall request and result register inputs
  always_comb begin
    load        = (state_q == IDLE) && bus.req_valid && !bus.flush;
    step        = (state_q == CALC) && !bus.flush;
    res_valid_d = (state_q == FIX) && !bus.flush;
    res_data_d  = res_valid_d ? dp_result : res_data_q;
    // rst gates stall so the output is low while reset is held even with req_valid up
    stall       = !rst && !bus.flush &&
                  (((state_q == IDLE) && bus.req_valid) ||
                   (state_q == CALC) || (state_q == FIX));
  end

  assign bus.stall_req = stall;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table with result scoreboard,
// plus flush and mid-operation reset sequences.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if bus();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 3;
`endif
    return 34;
  endfunction

  // Present an op at a negedge (start of T0); optionally push its expected result
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    if (push) exp_q.push_back(exp);
  endtask

  // Called during T0: checks stall each cycle, latency, result, and the one-cycle pulse
  task automatic wait_result(input logic [2:0] op, input string tag);
    int          lat;
    int          t;
    bit          got;
    logic [31:0] e;
    lat = exp_lat(op);
    got = 1'b0;
    #1;
    check({tag, " stall T0"}, 32'(bus.stall_req), 32'd1);
    for (t = 1; t <= 100; t++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
      if (t < lat) check({tag, " stall busy"}, 32'(bus.stall_req), 32'd1);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    if (got) begin
      check({tag, " latency"}, 32'(t), 32'(lat));
      check({tag, " stall DONE"}, 32'(bus.stall_req), 32'd0);
      check({tag, " res_data"}, bus.res_data, e);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s timeout: no res_valid within 100 cycles, expected data 0x%08h", tag, e);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " res_valid pulse"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        32'd2};
    vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0};
    vecs[12] = '{OP_MUL,    32'h12345678, 32'd9,        32'hA3D70A38};
    vecs[13] = '{OP_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[14] = '{OP_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3};
    vecs[15] = '{OP_REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset stall_req", 32'(bus.stall_req), 32'd0);
    check("reset res_valid", 32'(bus.res_valid), 32'd0);
    check("reset res_data", bus.res_data, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_result(vecs[i].op, $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // Flush a DIV at T10, then a MUL must run normally
    drive_op(OP_DIV, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    #1;
    check("flush stall_req", 32'(bus.stall_req), 32'd0);
    check("flush res_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk);
    #1;
    check("flush state IDLE", 32'(dut.state_q), 32'(IDLE));
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.res_valid || bus.stall_req) seen++;
    end
    check("flush no activity", 32'(seen), 32'd0);
    drive_op(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_result(OP_MUL, "post-flush mul");

    // Reset at T5 with req_valid held: outputs clear at once, op restarts after release
    drive_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst stall_req", 32'(bus.stall_req), 32'd0);
    check("midrst res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst res_data", bus.res_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_result(OP_DIVU, "post-reset divu");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
